// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_arb_pkg: shared state encodings and threshold reset constants     |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package fifo_arb_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int C_DEF_AF = 6;
  localparam int C_DEF_AE = 1;

endpackage
`default_nettype wire

// File: rtl/rr_grant_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_grant_sel: rotate-priority encoder, first request after i_last      |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module rr_grant_sel #(
  parameter int NUM_Q  = 4,
  parameter int QSEL_W = 2
) (
  input  logic [NUM_Q-1:0]  i_req,
  input  logic [QSEL_W-1:0] i_last,
  output logic [QSEL_W-1:0] o_gnt_id,
  output logic              o_gnt_v
);

  logic [QSEL_W-1:0] w_idx;

  // Walk from lowest to highest priority so the nearest request wins last.
  always_comb begin
    o_gnt_id = '0;
    o_gnt_v  = 1'b0;
    w_idx    = '0;
    for (int k = NUM_Q; k >= 1; k--) begin
      w_idx = i_last + QSEL_W'(k);
      if (i_req[w_idx]) begin
        o_gnt_id = w_idx;
        o_gnt_v  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_rr_arbiter: round-robin drain of NUM_Q ingress FIFOs downstream   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module fifo_rr_arbiter #(
  parameter int DATA_SIZE = 6,
  parameter int NUM_Q     = 4,
  parameter int QSEL_W    = 2,
  parameter int DEF_AF    = fifo_arb_pkg::C_DEF_AF,
  parameter int DEF_AE    = fifo_arb_pkg::C_DEF_AE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [DATA_SIZE-1:0]       umb_af_in,
  input  logic [DATA_SIZE-1:0]       umb_ae_in,
  input  logic [NUM_Q-1:0]           fifo_empty,
  input  logic [NUM_Q-1:0]           fifo_error,
  input  logic [NUM_Q*DATA_SIZE-1:0] fifo_data,
  input  logic                       dest_pause,
  input  logic                       dest_full,
  input  logic                       dest_error,
  output logic [NUM_Q-1:0]           fifo_pop,
  output logic                       dest_push,
  output logic [DATA_SIZE-1:0]       dest_data,
  output logic [DATA_SIZE-1:0]       umb_almost_full,
  output logic [DATA_SIZE-1:0]       umb_almost_empty,
  output logic [QSEL_W-1:0]          grant_id,
  output logic [2:0]                 state,
  output logic                       idle,
  output logic [7:0]                 push_count
);
  import fifo_arb_pkg::*;

  state_t                r_state;
  logic                  r_pend_v;
  logic [QSEL_W-1:0]     r_pend_id;
  logic [QSEL_W-1:0]     r_grant;
  logic [7:0]            r_count;
  logic [DATA_SIZE-1:0]  r_af;
  logic [DATA_SIZE-1:0]  r_ae;

  logic [DATA_SIZE-1:0]  w_qdata [NUM_Q];
  logic [QSEL_W-1:0]     w_gnt_id;
  logic                  w_gnt_v;
  logic                  w_any_req;
  logic                  w_any_err;
  logic                  w_pop_en;

  for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_unpack
    assign w_qdata[gi] = fifo_data[gi*DATA_SIZE +: DATA_SIZE];
  end

  rr_grant_sel #(
    .NUM_Q  (NUM_Q),
    .QSEL_W (QSEL_W)
  ) u_sel (
    .i_req    (~fifo_empty),
    .i_last   (r_grant),
    .o_gnt_id (w_gnt_id),
    .o_gnt_v  (w_gnt_v)
  );

  assign w_any_req = |(~fifo_empty);
  assign w_any_err = (|fifo_error) | dest_error;
  // Pop reacts to this cycle's empty flags so a single-entry FIFO is never read twice.
  assign w_pop_en  = (r_state == ST_ACTIVE) && !dest_pause && !dest_full && !init && w_gnt_v;

  assign fifo_pop         = w_pop_en ? (NUM_Q'(1) << w_gnt_id) : '0;
  assign dest_push        = r_pend_v;
  assign dest_data        = r_pend_v ? w_qdata[r_pend_id] : '0;
  assign umb_almost_full  = r_af;
  assign umb_almost_empty = r_ae;
  assign grant_id         = r_grant;
  assign state            = r_state;
  assign idle             = (r_state == ST_IDLE);
  assign push_count       = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RESET;
      r_pend_v  <= 1'b0;
      r_pend_id <= '0;
      r_grant   <= QSEL_W'(NUM_Q - 1);
      r_count   <= 8'd0;
      r_af      <= DATA_SIZE'(DEF_AF);
      r_ae      <= DATA_SIZE'(DEF_AE);
    end else begin
      r_pend_v <= w_pop_en;
      if (w_pop_en) begin
        r_pend_id <= w_gnt_id;
        r_grant   <= w_gnt_id;
      end
      if (r_pend_v) begin
        r_count <= r_count + 8'd1;
      end

      if (r_state == ST_RESET) begin
        r_state <= ST_INIT;
      end else if (w_any_err || r_state == ST_ERROR) begin
        r_state <= ST_ERROR;
      end else begin
        case (r_state)
          ST_INIT: begin
            if (init) begin
              r_af <= umb_af_in;
              r_ae <= umb_ae_in;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_IDLE: begin
            if (init)           r_state <= ST_INIT;
            else if (w_any_req) r_state <= ST_ACTIVE;
          end
          ST_ACTIVE: begin
            // Leaving ACTIVE waits for the in-flight word to land downstream.
            if (init) begin
              if (!r_pend_v) r_state <= ST_INIT;
            end else if (!w_any_req && !r_pend_v) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_ERROR;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
